// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package bit_serial_adder_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  // 2'd3 is unused; the FSM falls back to IDLE if it ever appears.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serial_adder_ctrl_if.sv
// Request/response bundle for the bit-serial adder.
interface bit_serial_adder_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/bit_serial_adder_ctrl_fa.sv
// Half-adder cell and the 1-bit full adder built from two of them.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;

  ha_cell u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
  ha_cell u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

  assign co = c1 | c2;
endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first.
module bit_serial_adder_ctrl
  import bit_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bit_serial_adder_ctrl_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;     // partial sum bits, newest at the top
  logic [WIDTH-1:0] res_cat;    // res_sh with this cycle's bit prepended
  logic [WIDTH-1:0] sum_q;
  logic             carry, cout_q, ovf_q;
  logic [CNT_W-1:0] count;
  logic             fa_s, fa_c;

  serial_fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  assign res_cat = {fa_s, res_sh};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: DONE is a single-cycle pulse, start only heard in IDLE
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = bus.start ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = (count == LAST) ? S_DONE : S_RUN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, serial shift, and result commit on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            count <= '0;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_cat[WIDTH-1:1];
          carry  <= fa_c;
          count  <= count + 1'b1;
          if (count == LAST) begin
            // carry here is the carry into the MSB
            sum_q  <= res_cat;
            cout_q <= fa_c;
            ovf_q  <= carry ^ fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Randomised self-checking bench for bit_serial_adder_ctrl.
module tb_bit_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [W-1:0] h_sum = '0;
  logic         h_cout = 1'b0;
  logic         h_ovf = 1'b0;

  bit_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain integer addition, signed range test for overflow
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                output logic [W-1:0] s, output logic co, output logic ov);
    longint u;
    int sx, sy, sg;
    u  = longint'(x) + longint'(y) + longint'(ci);
    s  = u[W-1:0];
    co = u[W];
    sx = $signed(x);
    sy = $signed(y);
    sg = sx + sy + int'(ci);
    ov = (sg > (2**(W-1) - 1)) || (sg < -(2**(W-1)));
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk({tag, ".idle_timeout"}, 1, 0);
  endtask

  // Called #1 after the accepting edge; returns edges until done was seen
  task automatic wait_done(input string tag, output int cyc);
    bit partial = 0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < W + 8) begin
      if (bus.sum !== h_sum || bus.cout !== h_cout || bus.ovf !== h_ovf) partial = 1;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".no_partial"}, partial, 0);
    chk({tag, ".latency"}, cyc, W);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic ci);
    logic [W-1:0] es;
    logic ec, eo;
    model(x, y, ci, es, ec, eo);
    chk({tag, ".sum"},  bus.sum,  es);
    chk({tag, ".cout"}, bus.cout, ec);
    chk({tag, ".ovf"},  bus.ovf,  eo);
    h_sum = es; h_cout = ec; h_ovf = eo;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci);
    int cyc;
    wait_idle(tag);
    @(negedge clk);
    bus.start = 1'b1; bus.a = x; bus.b = y; bus.cin = ci;
    @(posedge clk); #1;
    chk({tag, ".busy_rise"}, bus.busy, 1);
    @(negedge clk);
    // scramble inputs after capture: result must not depend on them
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    wait_done(tag, cyc);
    check_result(tag, x, y, ci);
    @(posedge clk); #1;
    chk({tag, ".done_fall"}, bus.done, 0);
    chk({tag, ".busy_fall"}, bus.busy, 0);
  endtask

  initial begin
    int cyc;
    bit extra;
    logic [W-1:0] ra, rb;
    logic rc;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.sum",  bus.sum,  0);
    chk("rst.cout", bus.cout, 0);
    chk("rst.ovf",  bus.ovf,  0);
    @(negedge clk); rst_n = 1'b1;

    do_op("d35_4a", 8'h35, 8'h4A, 1'b0);
    do_op("dff_01", 8'hFF, 8'h01, 1'b0);
    do_op("d7f_01", 8'h7F, 8'h01, 1'b0);
    do_op("dff_ff", 8'hFF, 8'hFF, 1'b1);

    // start held high: restart only after DONE, with the a present then
    wait_idle("hold");
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    @(posedge clk); #1;
    chk("hold.busy_rise", bus.busy, 1);
    @(negedge clk); bus.a = 8'hAA;
    wait_done("hold1", cyc);
    check_result("hold1", 8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    chk("hold.idle_gap", bus.busy, 0);
    @(posedge clk); #1;
    chk("hold.reaccept", bus.busy, 1);
    @(negedge clk); bus.start = 1'b0;
    wait_done("hold2", cyc);
    check_result("hold2", 8'hAA, 8'h20, 1'b0);
    @(posedge clk); #1;

    // async reset in the middle of RUN
    do_op("pre_rst", 8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h05; bus.b = 8'h09; bus.cin = 1'b0;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.busy", bus.busy, 0);
    chk("arst.done", bus.done, 0);
    chk("arst.sum",  bus.sum,  0);
    chk("arst.cout", bus.cout, 0);
    chk("arst.ovf",  bus.ovf,  0);
    h_sum = '0; h_cout = 1'b0; h_ovf = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_op("post_rst", 8'h01, 8'h02, 1'b0);

    // start only during the DONE cycle is ignored
    wait_idle("dn");
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); bus.start = 1'b0;
    wait_done("dn", cyc);
    check_result("dn", 8'h12, 8'h34, 1'b0);
    @(negedge clk); bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h66;
    @(posedge clk); #1;
    chk("dn.ign_busy", bus.busy, 0);
    chk("dn.ign_done", bus.done, 0);
    @(negedge clk); bus.start = 1'b0;
    extra = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra = 1;
    end
    chk("dn.no_second", extra, 0);
    chk("dn.sum_held", bus.sum, h_sum);

    // random operands
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_op("rnd", ra, rb, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
